// File: rtl/acc_rr_scheduler.sv
// Round-robin scheduler that lends one shared accumulator datapath to NUM_REQ requesters,
// running one burst job at a time and returning a tagged sum/overflow result.
module acc_rr_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned SUM_W   = 16,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]        gnt,
  input  logic [NUM_REQ-1:0]        s_valid,
  input  logic [NUM_REQ*DATA_W-1:0] s_data,
  output logic [NUM_REQ-1:0]        s_ready,
  output logic                      acc_clr,
  output logic                      acc_en,
  output logic [DATA_W-1:0]         acc_data,
  input  logic [SUM_W-1:0]          acc_sum,
  input  logic                      acc_carry,
  output logic                      res_valid,
  output logic [ID_W-1:0]           res_id,
  output logic [SUM_W-1:0]          res_sum,
  output logic                      res_ovf,
  input  logic                      res_ready
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_RESULT} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]    gidx_q, gidx_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               en_dly_q;
  logic               res_valid_q, res_valid_d;
  logic [ID_W-1:0]    res_id_q, res_id_d;
  logic [SUM_W-1:0]   res_sum_q, res_sum_d;
  logic               res_ovf_q, res_ovf_d;

  logic               win_found;
  logic [ID_W-1:0]    win_idx;
  logic [LEN_W-1:0]   win_len;
  int unsigned        cand;
  logic               sel_valid;
  logic [DATA_W-1:0]  sel_data;

  // Round-robin search starting at the pointer, wrapping past the last requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_len   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_found && req[ID_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(cand);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (32'(win_idx) == i) win_len = req_len[i*LEN_W +: LEN_W];
    end
  end

  // Sample lane of the granted requester.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) begin
        sel_valid = s_valid[i];
        sel_data  = s_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      gidx_q      <= '0;
      ptr_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      en_dly_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_sum_q   <= '0;
      res_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gidx_q      <= gidx_d;
      ptr_q       <= ptr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      en_dly_q    <= acc_en;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_sum_q   <= res_sum_d;
      res_ovf_q   <= res_ovf_d;
    end
  end

  // Job sequencing; the carry seen one cycle after an add feeds the sticky overflow.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gidx_d      = gidx_q;
    ptr_d       = ptr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q | (en_dly_q & acc_carry);
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_sum_d   = res_sum_q;
    res_ovf_d   = res_ovf_q;
    s_ready     = '0;
    acc_clr     = 1'b0;
    acc_en      = 1'b0;
    acc_data    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gnt_d   = NUM_REQ'(1) << win_idx;
          gidx_d  = win_idx;
          len_d   = win_len;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        acc_clr = 1'b1;
        ovf_d   = 1'b0;
        cnt_d   = '0;
        state_d = (len_q != '0) ? S_STREAM : S_DRAIN;
      end
      S_STREAM: begin
        s_ready = gnt_q;
        if (sel_valid) begin
          acc_en   = 1'b1;
          acc_data = sel_data;
          cnt_d    = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        res_sum_d   = acc_sum;
        res_ovf_d   = ovf_q | (en_dly_q & acc_carry);
        res_id_d    = gidx_q;
        res_valid_d = 1'b1;
        state_d     = S_RESULT;
      end
      S_RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          gnt_d       = '0;
          ptr_d       = (gidx_q == ID_W'(NUM_REQ - 1)) ? '0 : gidx_q + ID_W'(1);
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign gnt       = gnt_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_sum   = res_sum_q;
  assign res_ovf   = res_ovf_q;

endmodule

// File: doc/acc_rr_scheduler.md
Name: acc_rr_scheduler

Overview:
- Shares one 8-bit-in / 16-bit-sum accumulator datapath between NUM_REQ requesters using round-robin arbitration.
- Each granted requester runs one burst job: clear, stream req_len samples, capture the sum and overflow, then return one tagged result.
- Sits between the sample sources and the accumulator; it owns the accumulator's clear, enable and data inputs.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_W, 8, sample width; matches accumulator data_in.
- SUM_W, 16, accumulator sum width.
- LEN_W, 8, burst-length field width.
- ID_W, $clog2(NUM_REQ), result tag width.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  job request per requester.
- req_len  in  NUM_REQ*LEN_W  burst length per requester; slice i = [i*LEN_W +: LEN_W].
- gnt  out  NUM_REQ  one-hot grant, registered.
- s_valid  in  NUM_REQ  sample valid per requester.
- s_data  in  NUM_REQ*DATA_W  sample data per requester.
- s_ready  out  NUM_REQ  sample ready; only the granted bit can be 1.
- acc_clr  out  1  accumulator synchronous clear.
- acc_en  out  1  accumulator add enable.
- acc_data  out  DATA_W  accumulator addend.
- acc_sum  in  SUM_W  accumulator sum.
- acc_carry  in  1  carry out of the most recent add.
- res_valid  out  1  result valid.
- res_id  out  ID_W  index of the requester that owns the result.
- res_sum  out  SUM_W  captured sum.
- res_ovf  out  1  1 if any add in the burst carried out.
- res_ready  in  1  result consumer ready.

Behaviour:
- Reset:
  - state=IDLE; gnt, s_ready, acc_clr, acc_en, acc_data, res_valid, res_id, res_sum, res_ovf all 0.
  - rr pointer=0, so requester 0 has highest priority.
  - Reset mid-job aborts the job immediately; no result is produced.
- Accumulator contract:
  - acc_clr=1 makes acc_sum 0 next cycle.
  - acc_en=1 makes acc_sum = acc_sum + acc_data (mod 2^SUM_W) next cycle, with acc_carry valid in that same next cycle.
- FSM IDLE:
  - Search from the rr pointer upward with wrap-around; the first set req bit wins.
  - On a winner: register gnt one-hot, latch len from that requester's req_len slice, go to CLEAR.
  - With no req, stay in IDLE with gnt=0.
- FSM CLEAR (1 cycle):
  - acc_clr=1; clear the sticky ovf and the sample count.
  - Go to STREAM if len!=0, else DRAIN.
- FSM STREAM:
  - s_ready[granted]=1.
  - A beat is accepted when s_valid & s_ready: acc_en=1 and acc_data=s_data slice, both combinational from the accepted beat; count increments.
  - With s_valid low, acc_en=0 and acc_data=0.
  - When the len-th beat is accepted, go to DRAIN; s_ready drops the following cycle.
- FSM DRAIN (1 cycle):
  - Capture res_sum<=acc_sum, res_ovf<=ovf | (en_d & acc_carry), res_id<=granted index.
  - Go to RESULT.
- FSM RESULT:
  - res_valid=1; res_id, res_sum and res_ovf are held stable until res_valid & res_ready.
  - On handshake: res_valid<=0, gnt<=0, rr pointer<=granted index+1 (wrap), go to IDLE.
- Sticky ovf: en_d is acc_en delayed by one cycle. Any cycle with en_d & acc_carry sets ovf.
- gnt is held from CLEAR through RESULT. Changes to req or req_len during a job are ignored; only the latched len is used.
- Latency (continuous s_valid): req sampled at cycle t; gnt and acc_clr at t+1; beats at t+2..t+L+1; DRAIN at t+L+2; res_valid at t+L+3.
- len=0: no s_ready, no acc_en; result is sum 0, ovf 0, res_valid at t+3.
- Throughput: at most one job in flight. A new grant is issued no earlier than the cycle after the result handshake.

Test Plan:
- Reset: assert rst 3 cycles with req=4'b1111 -> gnt=0, s_ready=0, acc_en=0, acc_clr=0, res_valid=0; after release, the first grant is 4'b0001.
- Single job: req[1], len=3, samples 0x10,0x20,0x30 back-to-back -> gnt=4'b0010 at t+1, res_valid at t+6, res_id=1, res_sum=0x0060, res_ovf=0.
- Fairness: req=4'b1111 held, all len=1, requester i sends i+1 -> grant order 0,1,2,3,0; res_sum sequence 1,2,3,4,1.
- Overflow: LEN_W=10, len=258, every sample 0xFF -> res_sum=0x00FE, res_ovf=1.
- Bubbles and backpressure: len=2 with s_valid low 2 cycles between beats, res_ready low 3 cycles -> acc_en only on accepted beats, res_sum stable while waiting, no new gnt until the handshake.
- len=0 and reset mid-STREAM:
  - len=0 -> s_ready never 1, res_sum=0 at t+3.
  - rst asserted after 2 of 5 beats -> all outputs 0 the next cycle, no result emitted.
